// File: rtl/regfile_dbg_pkg.sv
// Shared types and defaults for the register-file debug access unit.
package regfile_dbg_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } dbg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_CLEAR,
        ST_RESP,
        ST_VERIFY
    } dbg_state_e;

endpackage

// File: rtl/regfile_dbg_master.sv
// Debug request channel to register-file port bridge (read port 1, write port 3).
// Optional write read-back check enabled by defining REGFILE_DBG_READBACK_EN.
module regfile_dbg_master
    import regfile_dbg_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_halted,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              core_stall,
    output logic [ADDR_W-1:0] rf_a1,
    input  logic [XLEN-1:0]   rf_rd1,
    output logic              rf_we3,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd3
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    dbg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [ADDR_W-1:0] idx_q;
    logic              reject;

    assign reject = !core_halted || (dbg_op_e'(req_op) == OP_RSVD);

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        core_stall = 1'b0;
        rf_a1      = '0;
        rf_we3     = 1'b0;
        rf_a3      = '0;
        rf_wd3     = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (reject) begin
                        state_d = ST_RESP;
                    end else begin
                        case (dbg_op_e'(req_op))
                            OP_READ:  state_d = ST_READ;
                            OP_WRITE: state_d = ST_WRITE;
                            default:  state_d = ST_CLEAR;
                        endcase
                    end
                end
            end
            ST_READ: begin
                core_stall = 1'b1;
                rf_a1      = addr_q;
                state_d    = ST_RESP;
            end
            ST_WRITE: begin
                core_stall = 1'b1;
                rf_we3     = 1'b1;
                rf_a3      = addr_q;
                rf_wd3     = wdata_q;
`ifdef REGFILE_DBG_READBACK_EN
                state_d    = ST_VERIFY;
`else
                state_d    = ST_RESP;
`endif
            end
`ifdef REGFILE_DBG_READBACK_EN
            ST_VERIFY: begin
                core_stall = 1'b1;
                rf_a1      = addr_q;
                state_d    = ST_RESP;
            end
`endif
            ST_CLEAR: begin
                core_stall = 1'b1;
                rf_we3     = 1'b1;
                rf_a3      = idx_q;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        idx_q     <= ADDR_W'(1);
                        rsp_rdata <= '0;
                        rsp_err   <= reject;
                    end
                end
                ST_READ: rsp_rdata <= rf_rd1;
`ifdef REGFILE_DBG_READBACK_EN
                ST_VERIFY: begin
                    rsp_rdata <= rf_rd1;
                    rsp_err   <= (rf_rd1 != wdata_q);
                end
`endif
                // Hold at the last index so the sweep can never revisit x0.
                ST_CLEAR: begin
                    if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dbg_master.sv
// Self-checking bench for regfile_dbg_master with a behavioural register-file load.
// Expectations follow REGFILE_DBG_READBACK_EN when it is defined.
module tb_regfile_dbg_master;

    localparam int unsigned NREGS = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_halted;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        core_stall;
    logic [4:0]  rf_a1;
    logic [31:0] rf_rd1;
    logic        rf_we3;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        tb_init;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem    [NREGS];
    logic [31:0] ref_rf [NREGS];

    always #5 clk = ~clk;

    regfile_dbg_master #(.XLEN(32), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n), .core_halted(core_halted),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .core_stall(core_stall),
        .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
    );

    // Register file load: combinational read, x0 hardwired to zero.
    assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : mem[rf_a1];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < int'(NREGS); i++) mem[i] <= 32'd0;
        end else if (rf_we3 && rf_a3 != 5'd0) begin
            mem[rf_a3] <= rf_wd3;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_core_stall"}, 32'(core_stall), 32'd0);
        chk({tag, "_rf_we3"}, 32'(rf_we3), 32'd0);
        chk({tag, "_rf_a1"}, 32'(rf_a1), 32'd0);
        chk({tag, "_rf_a3"}, 32'(rf_a3), 32'd0);
        chk({tag, "_rf_wd3"}, rf_wd3, 32'd0);
    endtask

    // One complete request/response exchange checked against the reference model.
    task automatic transact(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd,
                            input logic halted, input int hold, input logic drop);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat, exp_we, edges, stall_n, we_n;
        exp_err = !halted || op == 2'b11;
        exp_rd  = 32'd0;
        exp_lat = 0;
        exp_we  = 0;
        if (!exp_err) begin
            case (op)
                2'b00: begin
                    exp_rd  = ref_rf[addr];
                    exp_lat = 1;
                end
                2'b01: begin
                    if (addr != 5'd0) ref_rf[addr] = wd;
                    exp_we  = 1;
                    exp_lat = 1;
`ifdef REGFILE_DBG_READBACK_EN
                    exp_lat = 2;
                    exp_rd  = ref_rf[addr];
                    exp_err = (ref_rf[addr] != wd);
`endif
                end
                default: begin
                    for (int i = 1; i < int'(NREGS); i++) ref_rf[i] = 32'd0;
                    exp_we  = int'(NREGS) - 1;
                    exp_lat = int'(NREGS) - 1;
                end
            endcase
        end

        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_op      = op;
        req_addr    = addr;
        req_wdata   = wd;
        core_halted = halted;
        rsp_ready   = 1'b0;
        @(negedge clk);
        if (drop) core_halted = 1'b0;
        req_addr  = 5'($urandom);
        req_wdata = $urandom;
        req_op    = 2'($urandom);
        edges   = 0;
        stall_n = 0;
        we_n    = 0;
        while (!rsp_valid && edges < 100) begin
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (op == 2'b00 && edges == 0 && !exp_err) chk("rf_a1_read", 32'(rf_a1), 32'(addr));
            if (core_stall) stall_n++;
            if (rf_we3) we_n++;
            @(negedge clk);
            edges++;
        end
        chk("rsp_latency", 32'(edges), 32'(exp_lat));
        chk("stall_cycles", 32'(stall_n), 32'(exp_lat));
        chk("we3_pulses", 32'(we_n), 32'(exp_we));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rf_we3_resp", 32'(rf_we3), 32'd0);
        for (int k = 0; k < hold; k++) begin
            chk("req_ready_resp", 32'(req_ready), 32'd0);
            chk("stall_resp", 32'(core_stall), 32'd0);
            @(negedge clk);
            chk("rsp_valid_held", 32'(rsp_valid), 32'd1);
            chk("rsp_rdata_held", rsp_rdata, exp_rd);
            chk("rsp_err_held", 32'(rsp_err), 32'(exp_err));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready   = 1'b0;
        req_valid   = 1'b0;
        core_halted = 1'b1;
        chk("rsp_valid_done", 32'(rsp_valid), 32'd0);
        chk("req_ready_done", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int r;
        for (int i = 0; i < int'(NREGS); i++) ref_rf[i] = 32'd0;
        tb_init     = 1'b1;
        rst_n       = 1'b0;
        core_halted = 1'b1;
        req_valid   = 1'b0;
        req_op      = 2'b00;
        req_addr    = 5'd0;
        req_wdata   = 32'd0;
        rsp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outs("reset");
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        rst_n   = 1'b1;
        tb_init = 1'b0;

        transact(2'b01, 5'd5, 32'hDEADBEEF, 1'b1, 0, 1'b0);
        transact(2'b00, 5'd5, 32'd0, 1'b1, 0, 1'b0);
        transact(2'b01, 5'd0, 32'h12345678, 1'b1, 0, 1'b0);
        transact(2'b00, 5'd0, 32'd0, 1'b1, 0, 1'b0);
        transact(2'b01, 5'd1, 32'd1, 1'b1, 0, 1'b0);
        transact(2'b01, 5'd31, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
        transact(2'b10, 5'd0, 32'd0, 1'b1, 1, 1'b0);
        transact(2'b00, 5'd1, 32'd0, 1'b1, 0, 1'b0);
        transact(2'b00, 5'd31, 32'd0, 1'b1, 0, 1'b0);
        transact(2'b01, 5'd3, 32'h0000_0033, 1'b1, 0, 1'b0);
        transact(2'b00, 5'd3, 32'd0, 1'b0, 0, 1'b0);
        transact(2'b11, 5'd3, 32'd0, 1'b1, 0, 1'b0);
        transact(2'b00, 5'd3, 32'd0, 1'b1, 5, 1'b0);
        transact(2'b01, 5'd7, 32'h7777_0007, 1'b1, 2, 1'b1);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            transact((r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11,
                     5'($urandom), $urandom, 1'($urandom_range(0, 7) != 0),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
        end

        for (int a = 1; a < int'(NREGS); a++) begin
            transact(2'b01, 5'(a), 32'h1000_0000 + 32'(a) * 32'h0101, 1'b1, 0, 1'b0);
        end
        @(negedge clk);
        req_valid   = 1'b1;
        req_op      = 2'b10;
        core_halted = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("clear_stall_pre_reset", 32'(core_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle_outs("clear_reset");
        chk("clear_reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("clear_reset_rsp_rdata", rsp_rdata, 32'd0);
        for (int i = 1; i <= 10; i++) ref_rf[i] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < int'(NREGS); a++) begin
            transact(2'b00, 5'(a), 32'd0, 1'b1, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
